// File: rtl/jsequencer_pkg.sv
// Shared definitions for the jcscpu step sequencer: phase encodings and
// the legal range of the step-count parameter.
package jsequencer_pkg;

  // Four-phase clock generator states.
  //   idle: no strobe, step lines may change on the way into this phase
  //   en  : enable strobe
  //   set : enable + set strobes
  //   hold: enable strobe, set released before the step ends
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EN   = 2'd1,
    PH_SET  = 2'd2,
    PH_HOLD = 2'd3
  } phase_e;

  localparam int NSTEPS_MIN = 2;
  localparam int NSTEPS_MAX = 16;

  // True when a step count can be built by the sequencer.
  function automatic logic nsteps_legal(input int n);
    return (n >= NSTEPS_MIN) && (n <= NSTEPS_MAX);
  endfunction

endpackage

// File: rtl/jsequencer_jdecoder.sv
// Binary-to-one-hot decoder: N address bits drive N2 output lines.
module jdecoder #(
  parameter int N  = 3,
  parameter int N2 = 8
) (
  input  logic [N-1:0]  a_i,
  output logic [N2-1:0] y_o
);

  // Raise exactly the output line selected by the address.
  always_comb begin
    y_o      = {N2{1'b0}};
    y_o[a_i] = 1'b1;
  end

endmodule

// File: rtl/jsequencer_jphase4.sv
// Four-phase enable/set clock generator. The phase advances one step per
// cycle while run_i is high and freezes otherwise. Strobes are decoded from
// the next phase and registered so they change on the same edge as the phase.
module jphase4
  import jsequencer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic step_end_o,
  output logic wclke_o,
  output logic wclks_o
);

  phase_e ph_q, ph_d;
  logic   wclke_q, wclke_d;
  logic   wclks_q, wclks_d;
  logic   step_end_s;

  // Next phase, end-of-step detect and strobe decode from the next phase.
  always_comb begin
    ph_d       = ph_q;
    step_end_s = 1'b0;
    if (run_i) begin
      case (ph_q)
        PH_IDLE: ph_d = PH_EN;
        PH_EN:   ph_d = PH_SET;
        PH_SET:  ph_d = PH_HOLD;
        PH_HOLD: begin
          ph_d       = PH_IDLE;
          step_end_s = 1'b1;
        end
        default: ph_d = PH_IDLE;
      endcase
    end else begin
      ph_d = ph_q;
    end
    wclke_d = (ph_d != PH_IDLE);
    wclks_d = (ph_d == PH_SET);
  end

  // Phase and strobe registers; reset parks the generator in idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q    <= PH_IDLE;
      wclke_q <= 1'b0;
      wclks_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      wclke_q <= wclke_d;
      wclks_q <= wclks_d;
    end
  end

  assign step_end_o = step_end_s;
  assign wclke_o    = wclke_q;
  assign wclks_o    = wclks_q;

endmodule

// File: rtl/jsequencer.sv
// jcscpu step sequencer: four-phase strobe generator plus an N-step one-hot
// stepper. A step lasts four advancing cycles; at each step end the stepper
// either moves on or wraps to step 1 (last step reached or restart asked).
module jsequencer
  import jsequencer_pkg::*;
#(
  parameter int NSTEPS = 6
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              wrun,
  input  logic              wrestart,
  output logic [NSTEPS-1:0] bos,
  output logic              wclke,
  output logic              wclks,
  output logic              wlast,
  output logic              wwrap
);

  localparam int SW  = $clog2(NSTEPS);
  localparam int SN2 = 1 << SW;
  localparam logic [SW-1:0] ST_LAST = SW'(NSTEPS - 1);

  // Step counts outside the supported range stop elaboration.
  if (!nsteps_legal(NSTEPS)) begin : g_bad_nsteps
    $error("jsequencer: NSTEPS=%0d outside %0d..%0d", NSTEPS, NSTEPS_MIN, NSTEPS_MAX);
  end

  logic [SW-1:0]     st_q, st_d;
  logic              rp_q, rp_d;
  logic [NSTEPS-1:0] bos_q, bos_d;
  logic              wlast_q, wlast_d;
  logic              wwrap_q, wwrap_d;
  logic              step_end_s;
  logic              wrap_s;
  logic [SN2-1:0]    dec_s;

  jphase4 u_phase (
    .clk_i      (wclk),
    .rst_i      (wrst),
    .run_i      (wrun),
    .step_end_o (step_end_s),
    .wclke_o    (wclke),
    .wclks_o    (wclks)
  );

  // Step counter and restart-pending flag. A restart request is remembered
  // even while paused and only takes effect when the current step ends.
  always_comb begin
    st_d   = st_q;
    rp_d   = rp_q | wrestart;
    wrap_s = 1'b0;
    if (step_end_s) begin
      wrap_s = rp_q | wrestart | (st_q == ST_LAST);
      if (wrap_s) begin
        st_d = {SW{1'b0}};
        rp_d = 1'b0;
      end else begin
        st_d = st_q + SW'(1);
        rp_d = 1'b0;
      end
    end else begin
      st_d = st_q;
    end
    wlast_d = (st_d == ST_LAST);
    wwrap_d = wrap_s;
  end

  jdecoder #(
    .N  (SW),
    .N2 (SN2)
  ) u_dec (
    .a_i (st_d),
    .y_o (dec_s)
  );

  if (SN2 > NSTEPS) begin : g_fold
    // Keep the low NSTEPS lines; an out-of-range step falls back to step 1
    // so the step lines stay one-hot.
    always_comb begin
      bos_d    = dec_s[NSTEPS-1:0];
      bos_d[0] = dec_s[0] | (|dec_s[SN2-1:NSTEPS]);
    end
  end else begin : g_exact
    assign bos_d = dec_s;
  end

  // Stepper state and registered status; outputs freeze while paused.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      st_q    <= {SW{1'b0}};
      rp_q    <= 1'b0;
      bos_q   <= {{(NSTEPS-1){1'b0}}, 1'b1};
      wlast_q <= 1'b0;
      wwrap_q <= 1'b0;
    end else begin
      st_q <= st_d;
      rp_q <= rp_d;
      if (wrun) begin
        bos_q   <= bos_d;
        wlast_q <= wlast_d;
        wwrap_q <= wwrap_d;
      end else begin
        bos_q   <= bos_q;
        wlast_q <= wlast_q;
        wwrap_q <= wwrap_q;
      end
    end
  end

  assign bos   = bos_q;
  assign wlast = wlast_q;
  assign wwrap = wwrap_q;

endmodule

// File: tb/tb_jsequencer.sv
// Directed bench for jsequencer: a free-run vector table for NSTEPS=6 plus
// hand-written reset, pause and restart sequences, and a sweep of NSTEPS=2/16.
module tb_jsequencer;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic        wrun = 1'b0;
  logic        wrestart = 1'b0;
  logic        run_sw = 1'b0;
  logic        nore = 1'b0;

  logic [5:0]  bos;
  logic        wclke, wclks, wlast, wwrap;
  logic [1:0]  bos2;
  logic        e2, s2, last2, wrap2;
  logic [15:0] bos16;
  logic        e16, s16, last16, wrap16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run;
    logic [5:0] bos;
    logic       e;
    logic       s;
    logic       last;
    logic       wrap;
  } vec_t;

  vec_t vec [25];

  jsequencer #(.NSTEPS(6)) dut (
    .wclk(wclk), .wrst(wrst), .wrun(wrun), .wrestart(wrestart),
    .bos(bos), .wclke(wclke), .wclks(wclks), .wlast(wlast), .wwrap(wwrap)
  );

  jsequencer #(.NSTEPS(2)) dut2 (
    .wclk(wclk), .wrst(wrst), .wrun(run_sw), .wrestart(nore),
    .bos(bos2), .wclke(e2), .wclks(s2), .wlast(last2), .wwrap(wrap2)
  );

  jsequencer #(.NSTEPS(16)) dut16 (
    .wclk(wclk), .wrst(wrst), .wrun(run_sw), .wrestart(nore),
    .bos(bos16), .wclke(e16), .wclks(s16), .wlast(last16), .wwrap(wrap16)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [5:0] b, input logic e,
                           input logic s, input logic l, input logic w);
    chk({name, ".bos"},   16'(bos),   16'(b));
    chk({name, ".wclke"}, 16'(wclke), 16'(e));
    chk({name, ".wclks"}, 16'(wclks), 16'(s));
    chk({name, ".wlast"}, 16'(wlast), 16'(l));
    chk({name, ".wwrap"}, 16'(wwrap), 16'(w));
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge, all DUTs at cycle 0.
  task automatic do_reset();
    wrun = 1'b0;
    wrestart = 1'b0;
    run_sw = 1'b0;
    wrst = 1'b1;
    @(negedge wclk);
    wrst = 1'b0;
    tick();
  endtask

  task automatic run_to(input int n);
    wrun = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int st_i;
    int ph_i;

    // Free-run expectations for NSTEPS=6, cycle k after reset release.
    for (int k = 0; k < 25; k++) begin
      st_i = (k / 4) % 6;
      ph_i = k % 4;
      vec[k].run  = 1'b1;
      vec[k].bos  = 6'(1 << st_i);
      vec[k].e    = (ph_i != 0);
      vec[k].s    = (ph_i == 2);
      vec[k].last = (st_i == 5);
      vec[k].wrap = (k == 24);
    end

    // Reset state.
    do_reset();
    check_out("reset", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Free run through one full instruction and the wrap.
    for (int k = 0; k < 25; k++) begin
      check_out($sformatf("run%0d", k), vec[k].bos, vec[k].e, vec[k].s, vec[k].last, vec[k].wrap);
      wrun = vec[k].run;
      tick();
    end

    // Asynchronous reset at step 4, phase 2, between edges.
    do_reset();
    run_to(14);
    check_out("pre_arst", 6'b001000, 1'b1, 1'b1, 1'b0, 1'b0);
    #3 wrst = 1'b1;
    #1 check_out("arst", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause at step 3, phase 2 for five cycles.
    do_reset();
    run_to(10);
    check_out("pause_in", 6'b000100, 1'b1, 1'b1, 1'b0, 1'b0);
    wrun = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("pause%0d", i), 6'b000100, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    wrun = 1'b1;
    tick();
    check_out("pause_ph3", 6'b000100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("pause_next", 6'b001000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart pulse at step 3, phase 1: step 3 completes, then back to step 1.
    do_reset();
    run_to(9);
    check_out("rs_in", 6'b000100, 1'b1, 1'b0, 1'b0, 1'b0);
    wrestart = 1'b1;
    tick();
    wrestart = 1'b0;
    check_out("rs_ph2", 6'b000100, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("rs_ph3", 6'b000100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("rs_wrap", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("rs_after", 6'b000001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart raised in the same cycle as phase 3 of step 2.
    do_reset();
    run_to(7);
    check_out("rs3_in", 6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
    wrestart = 1'b1;
    tick();
    wrestart = 1'b0;
    check_out("rs3_wrap", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1);

    // Restart pulsed while paused is applied at the next step end.
    do_reset();
    run_to(5);
    check_out("rsp_in", 6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
    wrun = 1'b0;
    wrestart = 1'b1;
    tick();
    wrestart = 1'b0;
    tick();
    tick();
    check_out("rsp_hold", 6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
    wrun = 1'b1;
    tick();
    check_out("rsp_ph2", 6'b000010, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("rsp_ph3", 6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("rsp_wrap", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1);

    // Parameter sweep: NSTEPS=2 (period 8) and NSTEPS=16 (period 64).
    do_reset();
    run_sw = 1'b1;
    for (int k = 0; k < 71; k++) begin
      chk($sformatf("sw2_onehot%0d", k), 16'($onehot(bos2)), 16'd1);
      chk($sformatf("sw2_bos%0d", k), 16'(bos2), 16'(1 << ((k / 4) % 2)));
      chk($sformatf("sw2_e%0d", k), 16'(e2), 16'((k % 4) != 0));
      chk($sformatf("sw2_s%0d", k), 16'(s2), 16'((k % 4) == 2));
      chk($sformatf("sw2_last%0d", k), 16'(last2), 16'(((k / 4) % 2) == 1));
      chk($sformatf("sw2_wrap%0d", k), 16'(wrap2), 16'((k > 0) && (k % 8 == 0)));
      chk($sformatf("sw16_onehot%0d", k), 16'($onehot(bos16)), 16'd1);
      chk($sformatf("sw16_bos%0d", k), bos16, 16'(1 << ((k / 4) % 16)));
      chk($sformatf("sw16_last%0d", k), 16'(last16), 16'(((k / 4) % 16) == 15));
      chk($sformatf("sw16_wrap%0d", k), 16'(wrap16), 16'((k > 0) && (k % 64 == 0)));
      chk($sformatf("sw16_s%0d", k), 16'(s16), 16'((k % 4) == 2));
      chk($sformatf("sw16_e%0d", k), 16'(e16), 16'((k % 4) != 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
